// File: rtl/risc_main_control.sv
// Multi-cycle main control FSM for the 16-bit RISC core: FETCH/DECODE/EXEC/MEM/WB.
// Optional macro RISC_ILLEGAL_TRAP_EN adds a TRAP state entered on an illegal opcode.
module risc_main_control #(
    parameter int PC_STEP = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic [1:0] ALUOp,
    output logic       alu_src,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       busy,
    output logic       illegal,
    output logic [2:0] dbg_state
);

    if (PC_STEP < 1) begin : g_step_chk
        $error("PC_STEP must be positive");
    end

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
`ifdef RISC_ILLEGAL_TRAP_EN
        ,
        TRAP   = 3'd5
`endif
    } state_t;

    localparam logic [3:0] OP_LW   = 4'b1000;
    localparam logic [3:0] OP_SW   = 4'b1001;
    localparam logic [3:0] OP_ADDI = 4'b1010;
    localparam logic [3:0] OP_BEQ  = 4'b1011;
    localparam logic [3:0] OP_BNE  = 4'b1100;
    localparam logic [3:0] OP_JMP  = 4'b1101;

    state_t     state, state_d;
    logic [3:0] op_q;

    function automatic logic is_rtype(input logic [3:0] op);
        return op <= 4'b0100;
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return is_rtype(op) || (op >= OP_LW && op <= OP_JMP);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            op_q  <= 4'b0000;
        end else begin
            state <= state_d;
            if (state == DECODE) op_q <= opcode;
        end
    end

    assign dbg_state = state;

    // Everything is gated by rst_n so the block is fully quiet while held in reset.
    always_comb begin
        state_d    = state;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        ALUOp      = 2'b00;
        alu_src    = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        busy       = 1'b0;
        illegal    = 1'b0;
        if (rst_n) begin
            case (state)
                FETCH: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = DECODE;
                    end
                end
                // DECODE acts on the live opcode; it is captured into op_q on this edge.
                DECODE: begin
                    busy = 1'b1;
                    if (!is_legal(opcode)) begin
                        illegal = 1'b1;
`ifdef RISC_ILLEGAL_TRAP_EN
                        state_d = TRAP;
`else
                        state_d = FETCH;
`endif
                    end else if (opcode == OP_JMP) begin
                        pc_write = 1'b1;
                        pc_src   = 2'b10;
                        state_d  = FETCH;
                    end else begin
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    busy = 1'b1;
                    if (is_rtype(op_q)) begin
                        state_d = WB;
                    end else begin
                        case (op_q)
                            OP_LW, OP_SW: begin
                                ALUOp   = 2'b10;
                                alu_src = 1'b1;
                                state_d = MEM;
                            end
                            OP_ADDI: begin
                                ALUOp   = 2'b10;
                                alu_src = 1'b1;
                                state_d = WB;
                            end
                            OP_BEQ, OP_BNE: begin
                                ALUOp    = 2'b01;
                                pc_src   = 2'b01;
                                pc_write = (op_q == OP_BEQ) ? zero : !zero;
                                state_d  = FETCH;
                            end
                            default: state_d = FETCH;
                        endcase
                    end
                end
                MEM: begin
                    busy    = 1'b1;
                    ALUOp   = 2'b10;
                    alu_src = 1'b1;
                    if (op_q == OP_LW) mem_read  = 1'b1;
                    else               mem_write = 1'b1;
                    if (mem_ready) state_d = (op_q == OP_LW) ? WB : FETCH;
                end
                WB: begin
                    busy       = 1'b1;
                    reg_write  = 1'b1;
                    reg_dst    = is_rtype(op_q);
                    mem_to_reg = (op_q == OP_LW);
                    state_d    = FETCH;
                end
`ifdef RISC_ILLEGAL_TRAP_EN
                TRAP: begin
                    busy = 1'b1;
                end
`endif
                default: state_d = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_risc_main_control.sv
// Directed bench for risc_main_control: per-cycle stimulus with hand-computed output vectors.
module tb_risc_main_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_read, mem_write, ir_write, pc_write;
    logic [1:0] pc_src, ALUOp;
    logic       alu_src, reg_dst, reg_write, mem_to_reg, busy, illegal;
    logic [2:0] dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [13:0] exp_q[$];

    always #5 clk = ~clk;

    risc_main_control #(.PC_STEP(2)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .ALUOp(ALUOp), .alu_src(alu_src), .reg_dst(reg_dst),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .busy(busy), .illegal(illegal),
        .dbg_state(dbg_state)
    );

    // {mem_read, mem_write, ir_write, pc_write, pc_src, ALUOp, alu_src, reg_dst, reg_write, mem_to_reg, busy, illegal}
    logic [13:0] outs;
    assign outs = {mem_read, mem_write, ir_write, pc_write, pc_src, ALUOp,
                   alu_src, reg_dst, reg_write, mem_to_reg, busy, illegal};

    function automatic logic [13:0] ev(input logic mr, mw, irw, pcw,
                                       input logic [1:0] pcs, aop,
                                       input logic as_, rd, rw, m2r, b, il);
        return {mr, mw, irw, pcw, pcs, aop, as_, rd, rw, m2r, b, il};
    endfunction

    task automatic check_eq(input string tag, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, settle, compare against the queued expectation, advance.
    task automatic cyc(input string tag, input logic rdy, input logic z,
                       input logic [3:0] op, input logic [13:0] exp);
        mem_ready = rdy;
        zero      = z;
        opcode    = op;
        exp_q.push_back(exp);
        #1;
        check_eq(tag, outs, exp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    logic [13:0] e_zero, e_fwait, e_frdy, e_dec, e_exi, e_mlw, e_msw;
    logic [13:0] e_wbr, e_wbl, e_wba, e_btk, e_bnt, e_jmp, e_ill;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        e_zero  = '0;
        e_fwait = ev(1,0,0,0,2'b00,2'b00,0,0,0,0,0,0);
        e_frdy  = ev(1,0,1,1,2'b00,2'b00,0,0,0,0,0,0);
        e_dec   = ev(0,0,0,0,2'b00,2'b00,0,0,0,0,1,0);
        e_exi   = ev(0,0,0,0,2'b00,2'b10,1,0,0,0,1,0);
        e_mlw   = ev(1,0,0,0,2'b00,2'b10,1,0,0,0,1,0);
        e_msw   = ev(0,1,0,0,2'b00,2'b10,1,0,0,0,1,0);
        e_wbr   = ev(0,0,0,0,2'b00,2'b00,0,1,1,0,1,0);
        e_wbl   = ev(0,0,0,0,2'b00,2'b00,0,0,1,1,1,0);
        e_wba   = ev(0,0,0,0,2'b00,2'b00,0,0,1,0,1,0);
        e_btk   = ev(0,0,0,1,2'b01,2'b01,0,0,0,0,1,0);
        e_bnt   = ev(0,0,0,0,2'b01,2'b01,0,0,0,0,1,0);
        e_jmp   = ev(0,0,0,1,2'b10,2'b00,0,0,0,0,1,0);
        e_ill   = ev(0,0,0,0,2'b00,2'b00,0,0,0,0,1,1);

        // Clock/reset: hold reset with memory ready so a gated-off fetch would show.
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = 4'b0000;
        #1;
        check_eq("reset_outputs", outs, e_zero);
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_held", outs, e_zero);
        rst_n = 1'b1;

        // R-type 0011; opcode changed after DECODE to prove it is latched.
        cyc("r_fetch_wait", 1'b0, 1'b0, 4'b0011, e_fwait);
        cyc("r_fetch",      1'b1, 1'b0, 4'b0011, e_frdy);
        cyc("r_decode",     1'b1, 1'b0, 4'b0011, e_dec);
        cyc("r_exec",       1'b1, 1'b0, 4'b1101, e_dec);
        cyc("r_wb",         1'b1, 1'b0, 4'b1000, e_wbr);

        // LW with two wait cycles in MEM.
        cyc("lw_fetch",     1'b1, 1'b0, 4'b1000, e_frdy);
        cyc("lw_decode",    1'b1, 1'b0, 4'b1000, e_dec);
        cyc("lw_exec",      1'b1, 1'b0, 4'b0000, e_exi);
        cyc("lw_mem_w1",    1'b0, 1'b0, 4'b0000, e_mlw);
        cyc("lw_mem_w2",    1'b0, 1'b0, 4'b0000, e_mlw);
        cyc("lw_mem_rdy",   1'b1, 1'b0, 4'b0000, e_mlw);
        cyc("lw_wb",        1'b1, 1'b0, 4'b0000, e_wbl);

        // SW, zero wait.
        cyc("sw_fetch",     1'b1, 1'b0, 4'b1001, e_frdy);
        cyc("sw_decode",    1'b1, 1'b0, 4'b1001, e_dec);
        cyc("sw_exec",      1'b1, 1'b0, 4'b1000, e_exi);
        cyc("sw_mem",       1'b1, 1'b0, 4'b1000, e_msw);

        // ADDI.
        cyc("addi_fetch",   1'b1, 1'b0, 4'b1010, e_frdy);
        cyc("addi_decode",  1'b1, 1'b0, 4'b1010, e_dec);
        cyc("addi_exec",    1'b1, 1'b0, 4'b1010, e_exi);
        cyc("addi_wb",      1'b1, 1'b0, 4'b1010, e_wba);

        // BEQ zero=1 taken, BNE zero=1 not taken, BNE zero=0 taken.
        cyc("beq_fetch",    1'b1, 1'b1, 4'b1011, e_frdy);
        cyc("beq_decode",   1'b1, 1'b1, 4'b1011, e_dec);
        cyc("beq_exec",     1'b1, 1'b1, 4'b1011, e_btk);
        cyc("bne_fetch",    1'b1, 1'b1, 4'b1100, e_frdy);
        cyc("bne_decode",   1'b1, 1'b1, 4'b1100, e_dec);
        cyc("bne_exec_z1",  1'b1, 1'b1, 4'b1100, e_bnt);
        cyc("bne2_fetch",   1'b1, 1'b0, 4'b1100, e_frdy);
        cyc("bne2_decode",  1'b1, 1'b0, 4'b1100, e_dec);
        cyc("bne_exec_z0",  1'b1, 1'b0, 4'b1100, e_btk);

        // JMP: two cycles.
        cyc("jmp_fetch",    1'b1, 1'b0, 4'b1101, e_frdy);
        cyc("jmp_decode",   1'b1, 1'b0, 4'b1101, e_jmp);

        // Illegal opcode 1111.
        cyc("ill_fetch",    1'b1, 1'b0, 4'b1111, e_frdy);
        cyc("ill_decode",   1'b1, 1'b0, 4'b1111, e_ill);
`ifdef RISC_ILLEGAL_TRAP_EN
        for (int i = 0; i < 22; i++) cyc("trap_hold", 1'b1, 1'b0, 4'b0000, e_dec);
        rst_n = 1'b0;
        #1;
        check_eq("trap_reset", outs, e_zero);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`else
        cyc("ill_next_fetch", 1'b1, 1'b0, 4'b0101, e_frdy);
        cyc("ill0101_decode", 1'b1, 1'b0, 4'b0101, e_ill);
`endif

        // Reset in the middle of a stalled LW memory access.
        cyc("rlw_fetch",    1'b1, 1'b0, 4'b1000, e_frdy);
        cyc("rlw_decode",   1'b1, 1'b0, 4'b1000, e_dec);
        cyc("rlw_exec",     1'b1, 1'b0, 4'b1000, e_exi);
        mem_ready = 1'b0;
        #1;
        check_eq("rlw_mem_wait", outs, e_mlw);
        rst_n = 1'b0;
        #1;
        check_eq("rlw_async_reset", outs, e_zero);
        @(posedge clk);
        #1;
        check_eq("rlw_in_reset", outs, e_zero);
        rst_n = 1'b1;
        cyc("rlw_after_fetch_wait", 1'b0, 1'b0, 4'b0000, e_fwait);
        cyc("rlw_after_fetch",      1'b1, 1'b0, 4'b0000, e_frdy);
        cyc("rlw_after_decode",     1'b1, 1'b0, 4'b0000, e_dec);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/risc_main_control.md
# risc_main_control

Multi-cycle main control unit for the 16-bit RISC core. It sequences each instruction through fetch, decode, execute, memory and writeback. It generates the datapath strobes and the 2-bit `ALUOp` consumed by the ALU control decoder: `00` means R-type, ALU function taken from opcode; `01` means subtract (branch compare); `10` means add (address/immediate). It sits between the instruction register and the datapath, and handshakes with the unified memory port.

## Interface
Parameters:
- `PC_STEP`, default 2: PC increment per instruction, in bytes.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  4  IR[15:12]; sampled only in DECODE.
- `zero`  in  1  ALU zero flag; sampled in EXEC for branches.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `ir_write`  out  1  load IR from memory data.
- `pc_write`  out  1  load PC (PC+`PC_STEP`, branch or jump target per `pc_src`).
- `pc_src`  out  2  `00` PC+step, `01` branch target, `10` jump target.
- `ALUOp`  out  2  to ALU control.
- `alu_src`  out  1  `1` selects immediate as ALU B operand.
- `reg_dst`  out  1  `1` selects rd (R-type), `0` selects rt.
- `reg_write`  out  1  register-file write enable.
- `mem_to_reg`  out  1  writeback data from memory.
- `busy`  out  1  high in every state except FETCH.
- `illegal`  out  1  single-cycle pulse on an undefined opcode.

## Operation
Opcode map:
- `0000`–`0100`: R-type (ALU_Cnt = opcode).
- `1000`: LW.
- `1001`: SW.
- `1010`: ADDI.
- `1011`: BEQ.
- `1100`: BNE.
- `1101`: JMP.
- Anything else is illegal.

States: FETCH, DECODE, EXEC, MEM, WB, and TRAP (TRAP exists only with the macro).

- FETCH: `mem_read=1`. Stays while `mem_ready=0`. On `mem_ready=1`, pulses `ir_write=1` and `pc_write=1` with `pc_src=00`, then goes to DECODE.
- DECODE:
  - Latches `opcode` into an internal register; all later states use the latched value.
  - JMP: `pc_write=1`, `pc_src=10`, then FETCH.
  - Illegal: `illegal=1`, then FETCH (or TRAP with the macro).
  - Otherwise go to EXEC.
- EXEC:
  - R-type: `ALUOp=00`, `alu_src=0`, then WB.
  - LW, SW, ADDI: `ALUOp=10`, `alu_src=1`. LW and SW go to MEM; ADDI goes to WB.
  - BEQ, BNE: `ALUOp=01`, `alu_src=0`, `pc_src=01`. `pc_write = zero` for BEQ and `!zero` for BNE, then FETCH.
- MEM:
  - LW drives `mem_read=1`; SW drives `mem_write=1`. Both hold `ALUOp=10` and `alu_src=1`.
  - Stays while `mem_ready=0`.
  - On ready, LW goes to WB and SW goes to FETCH.
- WB: `reg_write=1`, then FETCH.
  - R-type: `reg_dst=1`, `mem_to_reg=0`.
  - LW: `reg_dst=0`, `mem_to_reg=1`.
  - ADDI: `reg_dst=0`, `mem_to_reg=0`.
- Unlisted outputs are 0 in every state.
- `mem_read` and `mem_write` are never high together.

## Timing
- All outputs are combinational from (state, latched opcode, `zero`, `mem_ready`). State updates on the rising edge of `clk`.
- Reset:
  - `rst_n` low forces state to FETCH and clears the latched opcode to `0000`, asynchronously.
  - While in reset, all outputs are 0 (`mem_read` is gated by `rst_n`) and `ALUOp=00`.
  - Fetch starts on the first edge after deassertion.
  - Reset asserted mid-instruction abandons it with no further strobes. A pending memory access is dropped.
- Cycles per instruction with zero memory wait: R-type 4, LW 5, SW 4, ADDI 4, BEQ/BNE 3, JMP 2, illegal 2.
- Each cycle of `mem_ready=0` adds one cycle in FETCH or MEM. Request outputs stay stable while waiting.
- `opcode` changes outside DECODE have no effect.

## Configuration
- `RISC_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode in DECODE pulses `illegal` and enters TRAP.
  - TRAP holds all strobes at 0 and `busy=1` until `rst_n` is asserted.
- Not defined:
  - TRAP state is absent.
  - An illegal opcode pulses `illegal` and returns to FETCH, so it executes as a 2-cycle NOP.

## Test plan
- Reset mid-LW: assert `rst_n=0` while in MEM with `mem_ready=0` -> all outputs 0 immediately. After release, the first cycle is FETCH with `mem_read=1`.
- R-type `0011`, `mem_ready` always 1 -> 4 cycles. EXEC shows `ALUOp=00`. WB shows `reg_write=1`, `reg_dst=1`. PC written exactly once.
- LW with 2 wait cycles in MEM -> 7 cycles total. `mem_read` held for 3 MEM cycles. WB shows `mem_to_reg=1`, `reg_dst=0`.
- BEQ with `zero=1`, then BNE with `zero=1` -> each takes 3 cycles with `ALUOp=01` in EXEC. BEQ gets `pc_write=1`, `pc_src=01` in EXEC; BNE gets no `pc_write` in EXEC.
- JMP -> 2 cycles. DECODE shows `pc_write=1`, `pc_src=10`. `ALUOp` stays 00 and `reg_write` stays 0 throughout.
- Opcode `1111`:
  - Without the macro: `illegal` pulses one cycle, then the next FETCH starts.
  - With the macro: `illegal` pulses, then TRAP persists with `busy=1` for 20+ cycles until reset.
